// File: rtl/tile_pattern_pkg.sv
// tile_pattern_pkg: shared enumerations and reset constants for the scrolling
// tile-pattern generator (tile_pattern_gen, tile_scroll_ctrl, tile_pattern_gen_if).
package tile_pattern_pkg;

  // Pattern selection, as driven on the mode input.
  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_VSTRIPE = 2'd1,
    MODE_HSTRIPE = 2'd2,
    MODE_DIAG    = 2'd3
  } tp_mode_e;

  // Scroll direction, as driven on the dir input.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } tp_dir_e;

  // Power-up palette: the red/black checkerboard of the predecessor block.
  localparam logic [5:0] TP_COLOR_A_RST = 6'b100100;
  localparam logic [5:0] TP_COLOR_B_RST = 6'b000000;

endpackage

// File: rtl/tile_pattern_gen_if.sv
// tile_pattern_gen_if: pixel-coordinate / control / colour bundle between the
// VGA timing side (master) and the pattern generator (slave).
interface tile_pattern_gen_if #(
  parameter int COORD_W = 10,
  parameter int RGB_W   = 6
);
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               active;
  logic               next_frame;
  logic [1:0]         mode;
  logic [1:0]         dir;
  logic [1:0]         speed;
  logic [RGB_W-1:0]   color_a;
  logic [RGB_W-1:0]   color_b;
  logic [RGB_W-1:0]   rgb;

  modport master (
    output x, y, active, next_frame, mode, dir, speed, color_a, color_b,
    input  rgb
  );

  modport slave (
    input  x, y, active, next_frame, mode, dir, speed, color_a, color_b,
    output rgb
  );
endinterface

// File: rtl/tile_scroll_ctrl.sv
// tile_scroll_ctrl: frame-start detection, pending frame-advance counter,
// dir/speed shadows and the x/y scroll offsets.
module tile_scroll_ctrl
  import tile_pattern_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int STEP_LOG2 = 2,
  parameter int PEND_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               next_frame_i,
  input  logic [1:0]         dir_i,
  input  logic [1:0]         speed_i,
  output logic [COORD_W-1:0] x_off_o,
  output logic [COORD_W-1:0] y_off_o,
  output logic               frame_start_o,
  output logic               consume_o
);

  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         speed_q, speed_d;
  logic [COORD_W-1:0] x_off_q, x_off_d;
  logic [COORD_W-1:0] y_off_q, y_off_d;
  logic [COORD_W-1:0] step;
  logic [2:0]         step_mult;
  logic               frame_start;
  logic               consume;
  logic               pend_sat;

  assign frame_start = (x_i == '0) && (y_i == '0);
  assign consume     = frame_start && (pend_q != '0);
  assign pend_sat    = &pend_q;

  // Next-state: shadows track inputs at frame start, so the scroll step
  // already uses the value being latched on that same edge.
  always_comb begin
    dir_d     = frame_start ? dir_i : dir_q;
    speed_d   = frame_start ? speed_i : speed_q;
    step_mult = {1'b0, speed_d} + 3'd1;
    step      = COORD_W'(step_mult) << STEP_LOG2;

    // A request landing on a consume cancels out; a saturated counter drops it.
    pend_d = pend_q;
    if (next_frame_i && !consume && !pend_sat) begin
      pend_d = pend_q + 1'b1;
    end else if (!next_frame_i && consume) begin
      pend_d = pend_q - 1'b1;
    end

    x_off_d = x_off_q;
    y_off_d = y_off_q;
    if (consume) begin
      case (tp_dir_e'(dir_d))
        DIR_RIGHT: x_off_d = x_off_q + step;
        DIR_LEFT:  x_off_d = x_off_q - step;
        DIR_DOWN:  y_off_d = y_off_q + step;
        default:   y_off_d = y_off_q - step;
      endcase
    end
  end

  // Scroll state registers; reset also flushes any queued frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      dir_q   <= 2'd0;
      speed_q <= 2'd0;
      x_off_q <= '0;
      y_off_q <= '0;
    end else begin
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
    end
  end

  assign x_off_o       = x_off_q;
  assign y_off_o       = y_off_q;
  assign frame_start_o = frame_start;
  assign consume_o     = consume;

endmodule

// File: rtl/tile_pattern_gen.sv
// tile_pattern_gen: scrolling tile-pattern generator (checker, stripes,
// diagonal) with frame-start shadowed controls and two-colour palette.
// Optional palette cycling is compiled in with TILE_PATTERN_CYCLE_EN.
module tile_pattern_gen
  import tile_pattern_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int TILE_LOG2 = 4,
  parameter int STEP_LOG2 = 2,
  parameter int PEND_W    = 4,
  parameter int RGB_W     = 6
`ifdef TILE_PATTERN_CYCLE_EN
  ,
  parameter int CYCLE_FRAMES = 32
`endif
) (
  input logic             clk,
  input logic             rst,
  tile_pattern_gen_if.slave bus
);

  localparam logic [COORD_W-1:0] TILE_MASK = COORD_W'(1) << TILE_LOG2;

  logic [COORD_W-1:0] x_off, y_off;
  logic               frame_start;
  logic               consume;
  tp_mode_e           mode_q;
  logic [RGB_W-1:0]   color_a_q, color_b_q;
  logic [RGB_W-1:0]   pal_a, pal_b;
  logic [COORD_W-1:0] sx, sy, sum;
  logic               sel;

  tile_scroll_ctrl #(
    .COORD_W  (COORD_W),
    .STEP_LOG2(STEP_LOG2),
    .PEND_W   (PEND_W)
  ) u_scroll (
    .clk          (clk),
    .rst          (rst),
    .x_i          (bus.x),
    .y_i          (bus.y),
    .next_frame_i (bus.next_frame),
    .dir_i        (bus.dir),
    .speed_i      (bus.speed),
    .x_off_o      (x_off),
    .y_off_o      (y_off),
    .frame_start_o(frame_start),
    .consume_o    (consume)
  );

  // Mode and colour shadows, refreshed every frame start regardless of queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_CHECKER;
      color_a_q <= RGB_W'(TP_COLOR_A_RST);
      color_b_q <= RGB_W'(TP_COLOR_B_RST);
    end else if (frame_start) begin
      mode_q    <= tp_mode_e'(bus.mode);
      color_a_q <= bus.color_a;
      color_b_q <= bus.color_b;
    end
  end

`ifdef TILE_PATTERN_CYCLE_EN
  localparam int CYC_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

  logic [CYC_W-1:0] cyc_q;
  logic             swap_q;

  // Count consumed frames; the wrap back to zero flips the palette.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      swap_q <= 1'b0;
    end else if (consume) begin
      if (cyc_q == CYC_W'(CYCLE_FRAMES - 1)) begin
        cyc_q  <= '0;
        swap_q <= ~swap_q;
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

  assign pal_a = swap_q ? color_b_q : color_a_q;
  assign pal_b = swap_q ? color_a_q : color_b_q;
`else
  // consume only feeds the palette cycler, which is not built here.
  logic consume_unused;
  assign consume_unused = consume;
  assign pal_a = color_a_q;
  assign pal_b = color_b_q;
`endif

  // Zero-latency pixel path: scrolled coordinate -> tile bit -> colour.
  always_comb begin
    sx  = bus.x + x_off;
    sy  = bus.y + y_off;
    sum = sx + sy;
    case (mode_q)
      MODE_CHECKER: sel = (|(sx & TILE_MASK)) ^ (|(sy & TILE_MASK));
      MODE_VSTRIPE: sel = |(sx & TILE_MASK);
      MODE_HSTRIPE: sel = |(sy & TILE_MASK);
      default:      sel = |(sum & TILE_MASK);
    endcase
    bus.rgb = bus.active ? (sel ? pal_a : pal_b) : '0;
  end

endmodule

// File: tb/tb_tile_pattern_gen.sv
// tb_tile_pattern_gen: randomized and directed checks of tile_pattern_gen
// against an arithmetic model of scroll queue, shadows and palette.
module tb_tile_pattern_gen;

  logic clk;
  logic rst;
  tile_pattern_gen_if #(.COORD_W(10), .RGB_W(6)) bus ();

  tile_pattern_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // stimulus copies
  int in_x, in_y, in_act, in_nf, in_mode, in_dir, in_speed, in_ca, in_cb;
  // reference model state
  int m_pend, m_xo, m_yo, m_mode, m_speed, m_ca, m_cb, m_swap, m_cyc;
  int exp_rgb;

  function automatic void model_reset();
    m_pend = 0; m_xo = 0; m_yo = 0;
    m_mode = 0; m_speed = 0;
    m_ca = 6'b100100; m_cb = 0;
    m_swap = 0; m_cyc = 0;
  endfunction

  // Effect of one rising clock edge with the current inputs.
  function automatic void model_edge();
    bit fs, cons;
    int step;
    fs   = (in_x == 0) && (in_y == 0);
    cons = fs && (m_pend > 0);
    if (fs) begin
      m_mode = in_mode; m_speed = in_speed; m_ca = in_ca; m_cb = in_cb;
    end
    if (cons) begin
      step = (in_speed + 1) * 4;
      case (in_dir)
        0: m_xo = (m_xo + step) % 1024;
        1: m_xo = (m_xo + 1024 - step) % 1024;
        2: m_yo = (m_yo + step) % 1024;
        default: m_yo = (m_yo + 1024 - step) % 1024;
      endcase
`ifdef TILE_PATTERN_CYCLE_EN
      m_cyc++;
      if (m_cyc == 32) begin
        m_cyc = 0;
        m_swap = 1 - m_swap;
      end
`endif
    end
    if (in_nf != 0 && cons) begin
      // request and consume cancel
    end else if (cons) begin
      m_pend--;
    end else if (in_nf != 0 && m_pend < 15) begin
      m_pend++;
    end
  endfunction

  function automatic int model_rgb(int x, int y, int act);
    int sx, sy, sel, pa, pb;
    if (act == 0) return 0;
    sx = (x + m_xo) % 1024;
    sy = (y + m_yo) % 1024;
    case (m_mode)
      0: sel = ((sx >> 4) ^ (sy >> 4)) & 1;
      1: sel = (sx >> 4) & 1;
      2: sel = (sy >> 4) & 1;
      default: sel = (((sx + sy) % 1024) >> 4) & 1;
    endcase
    pa = m_swap ? m_cb : m_ca;
    pb = m_swap ? m_ca : m_cb;
    return sel ? pa : pb;
  endfunction

  task automatic apply(input int x, input int y, input int act, input int nf);
    in_x = x; in_y = y; in_act = act; in_nf = nf;
    bus.x = 10'(x); bus.y = 10'(y);
    bus.active = act[0]; bus.next_frame = nf[0];
    bus.mode = 2'(in_mode); bus.dir = 2'(in_dir); bus.speed = 2'(in_speed);
    bus.color_a = 6'(in_ca); bus.color_b = 6'(in_cb);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse();
    apply($urandom_range(1, 1023), $urandom_range(0, 1023), 1, 1);
    tick();
  endtask

  task automatic frame(input int nf);
    apply(0, 0, 1, nf);
    tick();
  endtask

  task automatic test_reset();
    in_mode = 1; in_dir = 0; in_speed = 0; in_ca = 6'b010101; in_cb = 6'b001001;
    rst = 1'b1;
    model_reset();
    apply(16, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b100100) begin
      failures++; $display("FAIL reset_color_a got=%b want=%b", bus.rgb, 6'b100100);
    end
    apply(0, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b000000) begin
      failures++; $display("FAIL reset_color_b got=%b want=%b", bus.rgb, 6'b000000);
    end
    apply(16, 0, 0, 0); #1;
    checks++;
    if (bus.rgb !== 6'b000000) begin
      failures++; $display("FAIL reset_inactive got=%b want=%b", bus.rgb, 6'b000000);
    end
    tick(); tick();
    rst = 1'b0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_queue();
    do_reset();
    in_mode = 0; in_dir = 0; in_speed = 0;
    in_ca = $urandom_range(1, 63); in_cb = in_ca ^ 6'b111111;
    repeat (3) pulse();
    repeat (3) frame(0);
    apply(4, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'(in_ca)) begin
      failures++; $display("FAIL queue_sx16 got=%b want=%b", bus.rgb, 6'(in_ca));
    end
    apply(24, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'(in_cb)) begin
      failures++; $display("FAIL queue_sx36 got=%b want=%b", bus.rgb, 6'(in_cb));
    end
    // queue now empty: a further frame start must not scroll
    frame(0);
    for (int i = 0; i < 6; i++) begin
      apply($urandom_range(1, 1023), $urandom_range(0, 1023), 1, 0); #1;
      exp_rgb = model_rgb(in_x, in_y, 1);
      checks++;
      if (bus.rgb !== 6'(exp_rgb)) begin
        failures++; $display("FAIL queue_drained x=%0d y=%0d got=%b want=%b", in_x, in_y, bus.rgb, 6'(exp_rgb));
      end
    end
    $display("test_queue done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_saturation();
    do_reset();
    in_mode = 1; in_dir = 0; in_speed = 0; in_ca = 6'b111000; in_cb = 6'b000111;
    repeat (20) pulse();
    for (int f = 0; f < 17; f++) begin
      frame(0);
      apply($urandom_range(1, 1023), $urandom_range(0, 1023), 1, 0); #1;
      exp_rgb = model_rgb(in_x, in_y, 1);
      checks++;
      if (bus.rgb !== 6'(exp_rgb)) begin
        failures++; $display("FAIL sat_frame%0d x=%0d got=%b want=%b", f, in_x, bus.rgb, 6'(exp_rgb));
      end
    end
    // 15 consumed steps of 4 -> x_off 60
    apply(4, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b000111) begin
      failures++; $display("FAIL sat_xoff60_b got=%b want=%b", bus.rgb, 6'b000111);
    end
    apply(0, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b111000) begin
      failures++; $display("FAIL sat_xoff60_a got=%b want=%b", bus.rgb, 6'b111000);
    end
    // simultaneous request and consume: net zero
    do_reset();
    repeat (2) pulse();
    frame(1);
    frame(0);
    frame(0);
    frame(0);
    apply(4, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b111000) begin
      failures++; $display("FAIL simultaneous_xoff12 got=%b want=%b", bus.rgb, 6'b111000);
    end
    $display("test_saturation done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_wrap();
    do_reset();
    in_mode = 0; in_dir = 1; in_speed = 3; in_ca = 6'b110011; in_cb = 6'b001100;
    pulse();
    frame(0);
    apply(0, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b110011) begin
      failures++; $display("FAIL wrap_left_x0 got=%b want=%b", bus.rgb, 6'b110011);
    end
    apply(16, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b001100) begin
      failures++; $display("FAIL wrap_left_x16 got=%b want=%b", bus.rgb, 6'b001100);
    end
    in_dir = 3;
    pulse();
    frame(0);
    apply(1, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b001100) begin
      failures++; $display("FAIL wrap_up_y0 got=%b want=%b", bus.rgb, 6'b001100);
    end
    apply(1, 16, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b110011) begin
      failures++; $display("FAIL wrap_up_y16 got=%b want=%b", bus.rgb, 6'b110011);
    end
    $display("test_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_tear_free();
    do_reset();
    in_mode = 0; in_dir = 0; in_speed = 0; in_ca = 6'b110000; in_cb = 6'b001100;
    frame(0);
    in_mode = 3; in_ca = 6'b000011;
    apply(16, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b110000) begin
      failures++; $display("FAIL tear_midframe got=%b want=%b", bus.rgb, 6'b110000);
    end
    for (int i = 0; i < 6; i++) begin
      apply($urandom_range(1, 1023), $urandom_range(1, 1023), 1, 0); #1;
      exp_rgb = model_rgb(in_x, in_y, 1);
      checks++;
      if (bus.rgb !== 6'(exp_rgb)) begin
        failures++; $display("FAIL tear_rest x=%0d y=%0d got=%b want=%b", in_x, in_y, bus.rgb, 6'(exp_rgb));
      end
      tick();
    end
    // pixel (0,0) of the next frame still shows the old checker
    apply(0, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b001100) begin
      failures++; $display("FAIL tear_pixel00 got=%b want=%b", bus.rgb, 6'b001100);
    end
    tick();
    apply(16, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b000011) begin
      failures++; $display("FAIL tear_diag_new got=%b want=%b", bus.rgb, 6'b000011);
    end
    apply(8, 0, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b001100) begin
      failures++; $display("FAIL tear_diag_off got=%b want=%b", bus.rgb, 6'b001100);
    end
    $display("test_tear_free done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_palette();
    int want;
    do_reset();
    in_mode = 2; in_dir = 0; in_speed = 0; in_ca = 6'b101010; in_cb = 6'b010101;
    for (int k = 1; k <= 64; k++) begin
      pulse();
      frame(0);
      apply(5, 16, 1, 0); #1;
`ifdef TILE_PATTERN_CYCLE_EN
      want = (((k / 32) % 2) == 1) ? in_cb : in_ca;
`else
      want = in_ca;
`endif
      checks++;
      if (bus.rgb !== 6'(want)) begin
        failures++; $display("FAIL palette_k%0d got=%b want=%b", k, bus.rgb, 6'(want));
      end
    end
    $display("test_palette done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    in_mode = 1; in_dir = 0; in_speed = 2; in_ca = 6'b100001; in_cb = 6'b011110;
    repeat (3) pulse();
    rst = 1'b1;
    model_reset();
    apply(40, 7, 1, 0);
    tick();
    rst = 1'b0;
    frame(0);
    apply(16, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b100001) begin
      failures++; $display("FAIL reset_abort_x16 got=%b want=%b", bus.rgb, 6'b100001);
    end
    apply(8, 1, 1, 0); #1;
    checks++;
    if (bus.rgb !== 6'b011110) begin
      failures++; $display("FAIL reset_abort_x8 got=%b want=%b", bus.rgb, 6'b011110);
    end
    $display("test_reset_midframe done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int fs;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        in_mode = $urandom_range(0, 3); in_dir = $urandom_range(0, 3);
        in_speed = $urandom_range(0, 3);
        in_ca = $urandom_range(0, 63); in_cb = $urandom_range(0, 63);
      end
      fs = ($urandom_range(0, 5) == 0);
      apply(fs ? 0 : $urandom_range(0, 1023), fs ? 0 : $urandom_range(0, 1023),
            ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0);
      #1;
      exp_rgb = model_rgb(in_x, in_y, in_act);
      checks++;
      if (bus.rgb !== 6'(exp_rgb)) begin
        failures++; $display("FAIL random_%0d x=%0d y=%0d got=%b want=%b", i, in_x, in_y, bus.rgb, 6'(exp_rgb));
      end
      tick();
    end
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    in_mode = 0; in_dir = 0; in_speed = 0; in_ca = 0; in_cb = 0;
    rst = 1'b1;
    model_reset();
    apply(1, 1, 1, 0);
    @(posedge clk); #1;
    test_reset();
    test_queue();
    test_saturation();
    test_wrap();
    test_tear_free();
    test_palette();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_pattern_gen.md
# tile_pattern_gen

Parametrised scrolling tile-pattern generator for the VGA pattern pipeline, successor to the fixed red/black checkerboard. It uses the same pixel-coordinate interface. It adds selectable patterns (checker, vertical stripes, horizontal stripes, diagonal), four scroll directions, variable speed and programmable two-colour palettes. All control inputs are shadow-latched at frame start, so a frame never tears. Frame-advance requests are queued and applied only at frame boundaries.

## Interface
- COORD_W, 10, width of x/y and of the scroll offsets
- TILE_LOG2, 4, tile edge = 2^TILE_LOG2 pixels
- STEP_LOG2, 2, base scroll step = 2^STEP_LOG2 pixels per consumed frame
- PEND_W, 4, width of the pending-frame counter
- RGB_W, 6, colour width
- CYCLE_FRAMES, 32, consumed frames between palette swaps (only with CYCLE_EN)
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- x  in  COORD_W  current pixel column
- y  in  COORD_W  current pixel row
- active  in  1  visible-area flag
- next_frame  in  1  single-cycle frame-advance request
- mode  in  2  0 checker, 1 vertical stripes, 2 horizontal stripes, 3 diagonal
- dir  in  2  0 right, 1 left, 2 down, 3 up
- speed  in  2  step multiplier minus one (1..4)
- color_a  in  RGB_W  "on" tile colour
- color_b  in  RGB_W  "off" tile colour
- rgb  out  RGB_W  pixel colour, combinational from x/y/active and registered state

## Operation
- Frame start is defined as x==0 && y==0, sampled on clk.
- **Pending counter:**
  - next_frame increments it, saturating at 2^PEND_W-1.
  - At frame start with pending!=0, it decrements by one.
  - If next_frame arrives in the same cycle as a consume, the net change is zero.
  - If next_frame arrives while the counter is saturated, it is dropped.
- **Shadow latch:** every frame start, mode/dir/speed/color_a/color_b are copied into shadow registers, whether or not a frame is pending. All pattern logic uses only the shadows.
- **Scroll:** at frame start with pending!=0, step = (speed_s+1) << STEP_LOG2.
  - The speed used is the value being latched that same cycle, i.e. the new input value.
  - dir 0: x_off += step. dir 1: x_off -= step. dir 2: y_off += step. dir 3: y_off -= step.
  - x_off and y_off are COORD_W bits wide and wrap modulo 2^COORD_W.
- **Pattern:**
  - sx = x + x_off and sy = y + y_off, both truncated to COORD_W.
  - a = sx[TILE_LOG2], b = sy[TILE_LOG2].
  - sel per mode: checker a^b; vertical stripes a; horizontal stripes b; diagonal (sx+sy)[TILE_LOG2], with the sum truncated to COORD_W.
- **Output:** rgb = active ? (sel ? pal_a : pal_b) : 0.
  - pal_a/pal_b equal the shadow colours, possibly swapped (see Configuration).
- **Reset values:**
  - pending 0, x_off 0, y_off 0.
  - Shadow mode 0, dir 0, speed 0.
  - Shadow color_a = 6'b100100, shadow color_b = 0.
  - Swap flag 0, cycle counter 0.
  - With active=0, rgb is 0. Otherwise the checkerboard at zero offset in red/black.
- Reset mid-frame aborts all queued frames immediately. The next frame start after release consumes nothing.

## Timing
- rgb has zero latency relative to x/y/active within a cycle.
- State updated at frame start affects pixels from the cycle after the frame-start edge onward. Pixel (0,0) of that frame uses the previous state.
- One consumed frame per frame start at most. A queue of N frames drains over N frames.
- Input changes between frame starts have no visible effect until the next frame start.

## Configuration
- Macro: TILE_PATTERN_CYCLE_EN.
- **Defined:**
  - A consumed-frame counter counts up to CYCLE_FRAMES-1.
  - On the consume that wraps it to 0, the swap flag toggles and pal_a/pal_b exchange.
  - The counter and the flag reset to 0.
- **Undefined:** no counter or flag exists; pal_a = color_a shadow and pal_b = color_b shadow permanently.

## Structure
- Package tile_pattern_pkg holds:
  - mode and dir enumerations;
  - reset colour constants TP_COLOR_A_RST = 6'b100100 and TP_COLOR_B_RST = 6'b000000.
- Sub-module tile_scroll_ctrl contains the pending counter, frame-start detection, shadow latching of dir/speed and the x_off/y_off update. Its outputs are x_off, y_off and a consume pulse.
- The top level holds the colour/mode shadows, the optional palette cycler and the combinational pattern/output logic.

## Test plan
- **Reset defaults:** reset, mode=0, active=1, x=16, y=0 -> rgb=6'b100100; x=0, y=0 -> rgb=0; active=0 -> rgb=0.
- **Queue and scroll:** 3 next_frame pulses, dir=0, speed=0 -> after 3 frame starts x_off=12 and pending=0; with y=0, pixel x=4 reads as sx=16, i.e. colour A.
- **Saturation and simultaneous events:**
  - 20 pulses -> pending=15.
  - next_frame coinciding with a consume -> pending unchanged.
- **Wrap and direction:** dir=1, speed=3, one frame -> x_off=1008 (wraps from 0). dir=3 -> y_off=1008.
- **Tear-free modes:** change mode to 3 and color_a to 6'b000011 mid-frame -> the rest of the frame is unchanged; the next frame shows the diagonal pattern in the new colour.
- **Palette cycle (with TILE_PATTERN_CYCLE_EN):** 32 consumed frames -> colours swap; 64 -> restored. Without the macro -> never swap.
